// File: rtl/top_decode1_pkg.sv
// Shared decode definitions: opcode constants, immediate formats, bubble
// instruction and the ID/EX register layout.
package top_decode1_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic [6:0] OpcLoad   = 7'h03;
  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcAuipc  = 7'h17;
  localparam logic [6:0] OpcStore  = 7'h23;
  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcJal    = 7'h6F;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_type_e;

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        valid;
  } id_ex_t;

  function automatic imm_type_e imm_type_of(logic [6:0] opcode);
    case (opcode)
      OpcLoad, OpcOpImm, OpcJalr: return ImmI;
      OpcStore:                   return ImmS;
      OpcBranch:                  return ImmB;
      OpcLui, OpcAuipc:           return ImmU;
      OpcJal:                     return ImmJ;
      default:                    return ImmNone;
    endcase
  endfunction

endpackage

// File: rtl/top_decode1_if.sv
// Decode-stage bus: fetch inputs, hazard controls, writeback port and the
// registered ID/EX outputs. master drives fetch/control/writeback.
interface top_decode1_if;
  logic [31:0] instruction_fetch;
  logic [31:0] pc_fetch;
  logic [31:0] next_pc_fetch;
  logic        pc_select_execute;
  logic        stall_decode;
  logic        reg_write_wb;
  logic [4:0]  rd_wb;
  logic [31:0] result_wb;

  logic [31:0] rs1_data_decode;
  logic [31:0] rs2_data_decode;
  logic [31:0] imm_ext_decode;
  logic [31:0] pc_decode;
  logic [31:0] next_pc_decode;
  logic [4:0]  rs1_decode;
  logic [4:0]  rs2_decode;
  logic [4:0]  rd_decode;
  logic [6:0]  opcode_decode;
  logic [2:0]  funct3_decode;
  logic        funct7b5_decode;
  logic        reg_write_decode;
  logic        mem_write_decode;
  logic        branch_decode;
  logic        jump_decode;
  logic        valid_decode;

  modport master (
    output instruction_fetch, pc_fetch, next_pc_fetch, pc_select_execute, stall_decode,
    output reg_write_wb, rd_wb, result_wb,
    input  rs1_data_decode, rs2_data_decode, imm_ext_decode, pc_decode, next_pc_decode,
    input  rs1_decode, rs2_decode, rd_decode, opcode_decode, funct3_decode, funct7b5_decode,
    input  reg_write_decode, mem_write_decode, branch_decode, jump_decode, valid_decode
  );

  modport slave (
    input  instruction_fetch, pc_fetch, next_pc_fetch, pc_select_execute, stall_decode,
    input  reg_write_wb, rd_wb, result_wb,
    output rs1_data_decode, rs2_data_decode, imm_ext_decode, pc_decode, next_pc_decode,
    output rs1_decode, rs2_decode, rd_decode, opcode_decode, funct3_decode, funct7b5_decode,
    output reg_write_decode, mem_write_decode, branch_decode, jump_decode, valid_decode
  );
endinterface

// File: rtl/register_file1.sv
// 32x32 register file, two combinational read ports, one write port.
// Optional macro WRITE_BYPASS_EN forwards a same-cycle write to the readers.
module register_file1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  // x0 is never written, so it stays at its reset value of zero.
  assign wr_en = we && (waddr != 5'd0);

  // Clear on reset, write on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Combinational reads, optionally forwarding the in-flight write.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
`ifdef WRITE_BYPASS_EN
    if (wr_en && (waddr == rs1_addr)) rs1_data = wdata;
    if (wr_en && (waddr == rs2_addr)) rs2_data = wdata;
`endif
  end

endmodule

// File: rtl/top_decode1.sv
// RV32I decode stage: IF/ID register, register file read, immediate and
// control decode, ID/EX register. Stall holds IF/ID and bubbles ID/EX;
// flush bubbles both and wins over stall.
module top_decode1
  import top_decode1_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input logic          clk,
  input logic          rst,
  top_decode1_if.slave bus
);

  logic [31:0] instr_q, pc_q, next_pc_q;
  logic        valid_q;
  logic [6:0]  opcode;
  logic [31:0] imm_ext, rs1_data, rs2_data;
  logic        reg_write, mem_write, branch, jump;
  id_ex_t      id_ex_d, id_ex_q;

  // IF/ID: capture fetch unless stalled; flush inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      next_pc_q <= '0;
      valid_q   <= 1'b0;
    end else if (bus.pc_select_execute) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      next_pc_q <= '0;
      valid_q   <= 1'b0;
    end else if (!bus.stall_decode) begin
      instr_q   <= bus.instruction_fetch;
      pc_q      <= bus.pc_fetch;
      next_pc_q <= bus.next_pc_fetch;
      valid_q   <= 1'b1;
    end
  end

  assign opcode = instr_q[6:0];

  register_file1 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr_q[19:15]),
    .rs2_addr (instr_q[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (bus.reg_write_wb),
    .waddr    (bus.rd_wb),
    .wdata    (bus.result_wb)
  );

  // Immediate assembly by instruction format, sign from bit 31.
  always_comb begin
    imm_ext = '0;
    case (imm_type_of(opcode))
      ImmI: imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
      ImmS: imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      ImmB: imm_ext = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                       instr_q[11:8], 1'b0};
      ImmU: imm_ext = {instr_q[31:12], 12'b0};
      ImmJ: imm_ext = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                       instr_q[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Control decode from the opcode.
  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    case (opcode)
      OpcLoad, OpcOpImm, OpcOp, OpcLui, OpcAuipc: reg_write = 1'b1;
      OpcJal, OpcJalr: begin
        reg_write = 1'b1;
        jump      = 1'b1;
      end
      OpcStore:  mem_write = 1'b1;
      OpcBranch: branch    = 1'b1;
      default: ;
    endcase
  end

  // ID/EX next state; an empty IF/ID slot also travels on as a bubble.
  always_comb begin
    id_ex_d = '0;
    if (valid_q && !bus.stall_decode && !bus.pc_select_execute) begin
      id_ex_d.rs1_data  = rs1_data;
      id_ex_d.rs2_data  = rs2_data;
      id_ex_d.imm_ext   = imm_ext;
      id_ex_d.pc        = pc_q;
      id_ex_d.next_pc   = next_pc_q;
      id_ex_d.rs1       = instr_q[19:15];
      id_ex_d.rs2       = instr_q[24:20];
      id_ex_d.rd        = instr_q[11:7];
      id_ex_d.opcode    = opcode;
      id_ex_d.funct3    = instr_q[14:12];
      id_ex_d.funct7b5  = instr_q[30];
      id_ex_d.reg_write = reg_write;
      id_ex_d.mem_write = mem_write;
      id_ex_d.branch    = branch;
      id_ex_d.jump      = jump;
      id_ex_d.valid     = 1'b1;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign bus.rs1_data_decode  = id_ex_q.rs1_data;
  assign bus.rs2_data_decode  = id_ex_q.rs2_data;
  assign bus.imm_ext_decode   = id_ex_q.imm_ext;
  assign bus.pc_decode        = id_ex_q.pc;
  assign bus.next_pc_decode   = id_ex_q.next_pc;
  assign bus.rs1_decode       = id_ex_q.rs1;
  assign bus.rs2_decode       = id_ex_q.rs2;
  assign bus.rd_decode        = id_ex_q.rd;
  assign bus.opcode_decode    = id_ex_q.opcode;
  assign bus.funct3_decode    = id_ex_q.funct3;
  assign bus.funct7b5_decode  = id_ex_q.funct7b5;
  assign bus.reg_write_decode = id_ex_q.reg_write;
  assign bus.mem_write_decode = id_ex_q.mem_write;
  assign bus.branch_decode    = id_ex_q.branch;
  assign bus.jump_decode      = id_ex_q.jump;
  assign bus.valid_decode     = id_ex_q.valid;

endmodule

// File: tb/tb_top_decode1.sv
// Scoreboard bench for top_decode1. Expected ID/EX contents are queued as
// instructions are fetched and compared on the cycle they are due; every
// other cycle must show a bubble.
module tb_top_decode1;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [3:0]  ctrl;  // {reg_write, mem_write, branch, jump}
    logic [31:0] d1, d2, pc, npc;
    int          due;
  } exp_t;

`ifdef WRITE_BYPASS_EN
  localparam logic [31:0] BypExp = 32'h1234_5678;
`else
  localparam logic [31:0] BypExp = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc;
  exp_t        q[$];
  exp_t        pend;
  logic        pend_v = 1'b0;
  exp_t        nop_e;

  top_decode1_if bus ();

  top_decode1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                              input logic [31:0] imm, input logic [3:0] ctrl,
                              input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7;
    e.imm = imm; e.ctrl = ctrl; e.d1 = d1; e.d2 = d2;
    e.pc = '0; e.npc = '0; e.due = 0;
    return e;
  endfunction

  function automatic logic any_out();
    return |{bus.rs1_data_decode, bus.rs2_data_decode, bus.imm_ext_decode, bus.pc_decode,
             bus.next_pc_decode, bus.rs1_decode, bus.rs2_decode, bus.rd_decode,
             bus.opcode_decode, bus.funct3_decode, bus.funct7b5_decode, bus.reg_write_decode,
             bus.mem_write_decode, bus.branch_decode, bus.jump_decode, bus.valid_decode};
  endfunction

  // One fetch cycle. Entered and left 1 time unit after a rising edge.
  task automatic drive(input logic [31:0] instr, input logic stall, input logic flush,
                       input logic wr, input logic [4:0] wrd, input logic [31:0] wdata,
                       input exp_t e);
    exp_t n;
    bus.instruction_fetch = instr;
    bus.pc_fetch          = pc;
    bus.next_pc_fetch     = pc + 32'd4;
    bus.stall_decode      = stall;
    bus.pc_select_execute = flush;
    bus.reg_write_wb      = wr;
    bus.rd_wb             = wrd;
    bus.result_wb         = wdata;
    n     = e;
    n.pc  = pc;
    n.npc = pc + 32'd4;
    if (flush) begin
      pend_v = 1'b0;
    end else if (!stall) begin
      if (pend_v) begin
        pend.due = cyc + 1;
        q.push_back(pend);
      end
      pend   = n;
      pend_v = 1'b1;
    end
    pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  // Compare the due entry, or demand a bubble.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() != 0 && q[0].due < cyc) begin
        e = q.pop_front();
        check_eq("missed_due", cyc, e.due);
      end
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check_eq("valid", {31'b0, bus.valid_decode}, 32'd1);
        check_eq("pc", bus.pc_decode, e.pc);
        check_eq("next_pc", bus.next_pc_decode, e.npc);
        check_eq("opcode", {25'b0, bus.opcode_decode}, {25'b0, e.op});
        check_eq("rd", {27'b0, bus.rd_decode}, {27'b0, e.rd});
        check_eq("rs1", {27'b0, bus.rs1_decode}, {27'b0, e.rs1});
        check_eq("rs2", {27'b0, bus.rs2_decode}, {27'b0, e.rs2});
        check_eq("funct3", {29'b0, bus.funct3_decode}, {29'b0, e.f3});
        check_eq("funct7b5", {31'b0, bus.funct7b5_decode}, {31'b0, e.f7});
        check_eq("imm", bus.imm_ext_decode, e.imm);
        check_eq("ctrl", {28'b0, bus.reg_write_decode, bus.mem_write_decode, bus.branch_decode,
                          bus.jump_decode}, {28'b0, e.ctrl});
        check_eq("rs1_data", bus.rs1_data_decode, e.d1);
        check_eq("rs2_data", bus.rs2_data_decode, e.d2);
      end else begin
        check_eq("bubble_valid", {31'b0, bus.valid_decode}, 32'd0);
        check_eq("bubble_fields", {31'b0, any_out()}, 32'd0);
      end
    end
  end

  initial begin
    nop_e = mk(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0, 4'b1000, 32'h0, 32'h0);
    pc = 32'h0000_1000;
    bus.instruction_fetch = 32'h0; bus.pc_fetch = 32'h0; bus.next_pc_fetch = 32'h0;
    bus.stall_decode = 1'b0; bus.pc_select_execute = 1'b0;
    bus.reg_write_wb = 1'b0; bus.rd_wb = 5'd0; bus.result_wb = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'b0, bus.valid_decode}, 32'd0);
    check_eq("rst_outputs", {31'b0, any_out()}, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5 ; lui x4 (writes x2) ; add x3,x2,x2 ; beq -4
    drive(32'h0050_0093, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 1'b0, 32'd5, 4'b1000, 32'h0, 32'h0));
    drive(32'h1234_5237, 0, 0, 1, 5'd2, 32'hDEAD_BEEF,
          mk(7'h37, 5'd4, 5'd8, 5'd3, 3'd5, 1'b0, 32'h1234_5000, 4'b1000, 32'h0, 32'h0));
    drive(32'h0021_01B3, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h33, 5'd3, 5'd2, 5'd2, 3'd0, 1'b0, 32'h0, 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    drive(32'hFE00_0EE3, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h63, 5'd29, 5'd0, 5'd0, 3'd0, 1'b1, 32'hFFFF_FFFC, 4'b0010, 32'h0, 32'h0));
    // lw x3,-4(x1) ; sw x2,8(x1) ; jal x1,-8 ; jalr x0,0(x1) ; unknown opcode
    drive(32'hFFC0_A183, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h03, 5'd3, 5'd1, 5'd28, 3'd2, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'h0, 32'h0));
    drive(32'h0020_A423, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h23, 5'd8, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 4'b0100, 32'h0, 32'hDEAD_BEEF));
    drive(32'hFF9F_F0EF, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h6F, 5'd1, 5'd31, 5'd25, 3'd7, 1'b1, 32'hFFFF_FFF8, 4'b1001, 32'h0, 32'h0));
    drive(32'h0000_8067, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 1'b0, 32'h0, 4'b1001, 32'h0, 32'h0));
    drive(32'hFFFF_FFFF, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0));

    // Same-cycle write of x5 while addi x6,x5,0 sits in IF/ID, then x0 write.
    drive(32'h0002_8313, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h13, 5'd6, 5'd5, 5'd0, 3'd0, 1'b0, 32'h0, 4'b1000, BypExp, 32'h0));
    drive(32'h0000_0013, 0, 0, 1, 5'd5, 32'h1234_5678, nop_e);
    drive(32'h0002_8313, 0, 0, 1, 5'd0, 32'hFFFF_FFFF,
          mk(7'h13, 5'd6, 5'd5, 5'd0, 3'd0, 1'b0, 32'h0, 4'b1000, 32'h1234_5678, 32'h0));
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);

    // add x8,x7,x0 held by a one-cycle stall (x7 written during the stall),
    // then stall together with flush gives two bubbles.
    drive(32'h0003_8433, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h33, 5'd8, 5'd7, 5'd0, 3'd0, 1'b0, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0));
    drive(32'h0000_0013, 1, 0, 1, 5'd7, 32'hA5A5_A5A5, nop_e);
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 1, 1, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 1, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 1, 0, 5'd0, 32'h0, nop_e);

    // Reset arriving mid-stall and mid-flush clears outputs at once.
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);
    check_eq("pre_rst_valid", {31'b0, bus.valid_decode}, 32'd1);
    bus.stall_decode      = 1'b1;
    bus.pc_select_execute = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", {31'b0, bus.valid_decode}, 32'd0);
    check_eq("rst_mid_outputs", {31'b0, any_out()}, 32'd0);
    q.delete();
    pend_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Register file cleared: x2 reads 0 again.
    drive(32'h0021_01B3, 0, 0, 0, 5'd0, 32'h0,
          mk(7'h33, 5'd3, 5'd2, 5'd2, 3'd0, 1'b0, 32'h0, 4'b1000, 32'h0, 32'h0));
    drive(32'h0000_0013, 0, 0, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 1, 0, 5'd0, 32'h0, nop_e);
    drive(32'h0000_0013, 0, 1, 0, 5'd0, 32'h0, nop_e);
    check_eq("queue_drain", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
